if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage plus IF/ID pipeline register of the RV32IM core; feeds PC_D/instruction_D to ID.
//  Owns PC_F and talks to instruction memory through a req/ready + rvalid handshake, one request in flight.
//  Takes redirects (PCnew_D/PCin1_D) and stalls (StallD) from decode, and halts on ebreak_D.
//  Buffers one fetched word while decode is stalled. Drops responses made stale by a redirect.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC_F value after reset.
//  NOP_INSN  32'h0000_0013  instruction_D value when the IF/ID slot is empty (addi x0,x0,0).
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst            in   1   synchronous reset, active-low
//  StallD         in   1   hazard unit: hold IF/ID register and PC_F
//  PCnew_D        in   1   taken branch/jump resolved in ID
//  PCin1_D        in   32  redirect target (bits [1:0] forced to 0)
//  ebreak_D       in   1   ebreak in ID: stop fetching until reset
//  imem_req_o     out  1   fetch request valid
//  imem_addr_o    out  32  fetch address, word aligned
//  imem_ready_i   in   1   imem accepts request this cycle
//  imem_rvalid_i  in   1   response valid
//  imem_rdata_i   in   32  response instruction
//  PC_D           out  32  IF/ID register: PC of instruction_D
//  instruction_D  out  32  IF/ID register: instruction to decode
//  valid_D        out  1   IF/ID slot holds a real instruction
// BEHAVIOUR
//  Reset (rst=0 at edge):
//   - PC_F=RESET_PC; state=IDLE; kill=0.
//   - PC_D=0, instruction_D=NOP_INSN, valid_D=0; buffer cleared.
//   - imem_req_o=0 during the reset cycle.
//   - Any request/response in flight is abandoned; rvalid is ignored outside WAIT.
//  States: IDLE, WAIT, HELD, HALT.
//   - IDLE: imem_req_o=1, imem_addr_o=PC_F; on imem_ready_i go to WAIT.
//   - WAIT, rvalid=1, kill=0, StallD=0:
//     - load PC_D=PC_F, instruction_D=rdata, valid_D=1; PC_F+=4.
//     - same cycle: imem_req_o=1 with addr PC_F+4 (back-to-back).
//     - stay in WAIT if ready, else go to IDLE.
//     - throughput: 1 insn/cycle with 1-cycle imem.
//   - WAIT, rvalid=1, StallD=1: store rdata and PC_F in buffer, go to HELD, no request; IF/ID unchanged.
//   - WAIT, rvalid=1, kill=1: discard response, kill<=0, go to IDLE; IF/ID unchanged.
//   - HELD: no request. When StallD=0, load buffer into IF/ID (valid_D=1), PC_F+=4, go to IDLE.
//   - HALT: imem_req_o=0, IF/ID holds NOP/valid_D=0; exit only by reset.
//  StallD=1: PC_D, instruction_D, valid_D hold; PC_F changes only through the buffer path above.
//  Redirect (PCnew_D & !StallD), priority over all but reset:
//   - PC_F<=PCin1_D&~3; IF/ID flushed (instruction_D=NOP_INSN, valid_D=0).
//   - IDLE: no request issued this cycle; next cycle requests the target.
//   - WAIT without rvalid: kill<=1.
//   - WAIT with rvalid: response discarded, go to IDLE.
//   - HELD: buffer dropped, go to IDLE.
//   - PCnew_D while StallD=1 is ignored.
//  ebreak_D & !StallD: flush IF/ID; go to HALT after any outstanding response is drained.
//   - A response arriving in the same cycle as ebreak_D is discarded.
//   - ebreak_D beats PCnew_D in the same cycle.
//  PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  Never more than one unanswered request; imem_req_o is never high in WAIT unless that cycle's rvalid is consumed.
// TESTING
//  1. Reset, imem 1-cycle, ready=1 -> requests 0x0,0x4,0x8 back-to-back; PC_D 0,4,8 on consecutive cycles; valid_D=1 from cycle 2.
//  2. Reset, then StallD=1 for 3 cycles while the 0x4 response arrives -> HELD, PC_D stays 0x0; on release PC_D=0x4, next request 0x8.
//  3. Reset, imem latency 3; PCnew_D=1, PCin1_D=0x100 while WAIT on 0x8 -> 0x8 data never reaches ID; next request 0x100; PC_D=0x100 valid.
//  4. PCin1_D=0x103 in the same cycle as rvalid -> response dropped, next addr 0x100, instruction_D=NOP_INSN and valid_D=0 for the flush cycle.
//  5. ebreak_D=1 with a request outstanding -> response drained, then imem_req_o=0 indefinitely; rst=0 -> fetch restarts at RESET_PC.
//  6. rst=0 mid-WAIT with late rvalid after reset -> ignored; first loaded instruction_D is from RESET_PC; PC_F 0xFFFFFFFC+4 wraps to 0.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
//
// One request may be in flight. A request is accepted on a cycle where
// imem_req_o and imem_ready_i are both high. Its response arrives later as a
// single-cycle imem_rvalid_i pulse with the instruction on imem_rdata_i.
//
// Signals
//   imem_req_o     fetch request valid            (fetch -> memory)
//   imem_addr_o    word-aligned fetch address     (fetch -> memory)
//   imem_ready_i   memory accepts request         (memory -> fetch)
//   imem_rvalid_i  response valid                 (memory -> fetch)
//   imem_rdata_i   response instruction word      (memory -> fetch)
//
// Modports
//   master  used by the fetch stage
//   slave   used by the instruction memory
interface if_fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the RV32IM core.
//
// Owns the fetch PC (PC_F) and fetches from instruction memory over the
// imem bus with at most one request outstanding. Fetched words are loaded
// into the IF/ID register (PC_D / instruction_D / valid_D) for decode.
// A word that arrives while decode is stalled is parked in a one-entry
// buffer. Redirects from decode flush IF/ID and drop any response that
// belongs to the old path. An ebreak in decode stops fetching until reset.
//
// Parameters
//   RESET_PC       PC_F value after reset
//   NOP_INSN       instruction_D value while the IF/ID slot is empty
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous reset, active low
//   StallD         hold IF/ID register and PC_F
//   PCnew_D        taken branch/jump resolved in decode
//   PCin1_D        redirect target (low two bits ignored)
//   ebreak_D       ebreak in decode, halt fetching
//   imem           instruction-memory bus (master side)
//   PC_D           IF/ID: PC of instruction_D
//   instruction_D  IF/ID: instruction for decode
//   valid_D        IF/ID slot holds a real instruction
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    StallD,
  input  logic                    PCnew_D,
  input  logic [31:0]             PCin1_D,
  input  logic                    ebreak_D,
  if_fetch_stage_if.master        imem,
  output logic [31:0]             PC_D,
  output logic [31:0]             instruction_D,
  output logic                    valid_D
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HELD = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state_q,    state_d;
  logic [31:0] pc_f_q,     pc_f_d;
  logic        kill_q,     kill_d;
  logic        drain_q,    drain_d;
  logic [31:0] buf_pc_q,   buf_pc_d;
  logic [31:0] buf_insn_q, buf_insn_d;
  logic [31:0] pc_d_q,     pc_d_d;
  logic [31:0] insn_d_q,   insn_d_d;
  logic        valid_d_q,  valid_d_d;

  logic        req_c;
  logic [31:0] addr_c;
  logic        redirect;
  logic        halt_go;
  logic [31:0] target;
  logic [31:0] pc_next;

  // ebreak outranks a redirect in the same cycle; both are ignored while
  // decode is stalled.
  assign halt_go  = ebreak_D & ~StallD;
  assign redirect = PCnew_D & ~StallD & ~ebreak_D;
  assign target   = PCin1_D & ~32'd3;
  assign pc_next  = pc_f_q + 32'd4;

  // State register, fetch PC, kill/drain flags, stall buffer and IF/ID.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_f_q     <= RESET_PC;
      kill_q     <= 1'b0;
      drain_q    <= 1'b0;
      buf_pc_q   <= 32'h0;
      buf_insn_q <= 32'h0;
      pc_d_q     <= 32'h0;
      insn_d_q   <= NOP_INSN;
      valid_d_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      kill_q     <= kill_d;
      drain_q    <= drain_d;
      buf_pc_q   <= buf_pc_d;
      buf_insn_q <= buf_insn_d;
      pc_d_q     <= pc_d_d;
      insn_d_q   <= insn_d_d;
      valid_d_q  <= valid_d_d;
    end
  end

  // Next-state and request logic.
  // When decode is not stalled it consumes the IF/ID slot every cycle, so
  // the slot becomes a bubble unless a new word is loaded into it. That same
  // default also performs the flush for redirects and ebreak.
  // kill marks an outstanding request whose response belongs to a path that
  // was redirected away; drain marks one that must be absorbed before HALT.
  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    kill_d     = kill_q;
    drain_d    = drain_q;
    buf_pc_d   = buf_pc_q;
    buf_insn_d = buf_insn_q;
    pc_d_d     = pc_d_q;
    insn_d_d   = insn_d_q;
    valid_d_d  = valid_d_q;
    req_c      = 1'b0;
    addr_c     = pc_f_q;

    if (!StallD) begin
      insn_d_d  = NOP_INSN;
      valid_d_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (halt_go) begin
          state_d = HALT;
        end else if (redirect) begin
          pc_f_d = target;
        end else begin
          req_c = 1'b1;
          if (imem.imem_ready_i) state_d = WAIT;
        end
      end

      WAIT: begin
        if (drain_q) begin
          if (imem.imem_rvalid_i) begin
            state_d = HALT;
            drain_d = 1'b0;
            kill_d  = 1'b0;
          end
        end else if (halt_go) begin
          kill_d = 1'b0;
          if (imem.imem_rvalid_i) state_d = HALT;
          else                    drain_d = 1'b1;
        end else if (redirect) begin
          pc_f_d = target;
          if (imem.imem_rvalid_i) begin
            state_d = IDLE;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (imem.imem_rvalid_i) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = IDLE;
          end else if (StallD) begin
            buf_pc_d   = pc_f_q;
            buf_insn_d = imem.imem_rdata_i;
            state_d    = HELD;
          end else begin
            // Load IF/ID and issue the next fetch in the same cycle so a
            // single-cycle memory sustains one instruction per clock.
            pc_d_d    = pc_f_q;
            insn_d_d  = imem.imem_rdata_i;
            valid_d_d = 1'b1;
            pc_f_d    = pc_next;
            req_c     = 1'b1;
            addr_c    = pc_next;
            state_d   = imem.imem_ready_i ? WAIT : IDLE;
          end
        end
      end

      HELD: begin
        if (halt_go) begin
          state_d = HALT;
        end else if (redirect) begin
          pc_f_d  = target;
          state_d = IDLE;
        end else if (!StallD) begin
          pc_d_d    = buf_pc_q;
          insn_d_d  = buf_insn_q;
          valid_d_d = 1'b1;
          pc_f_d    = buf_pc_q + 32'd4;
          state_d   = IDLE;
        end
      end

      HALT: begin
        insn_d_d  = NOP_INSN;
        valid_d_d = 1'b0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // No request may escape during the reset cycle, whatever the state.
  assign imem.imem_req_o  = req_c & rst;
  assign imem.imem_addr_o = addr_c;

  assign PC_D          = pc_d_q;
  assign instruction_D = insn_d_q;
  assign valid_D       = valid_d_q;

endmodule
